// File: rtl/map_pkg.sv
// Shared types and constants for the scrolling map draw stage:
// texel/address typedefs, FSM state enums and the camera clamp helper.
package map_pkg;

  localparam int MAP_DIM = 256;
  localparam int VGA_W   = 26;

  typedef logic [7:0]  texel_t;
  typedef logic [15:0] map_addr_t;

  typedef enum logic {
    CAM_ACTIVE = 1'b0,
    CAM_BLANK  = 1'b1
  } cam_state_t;

  typedef enum logic [1:0] {
    PRB_IDLE = 2'd0,
    PRB_ADDR = 2'd1,
    PRB_READ = 2'd2
  } probe_state_t;

  // Largest camera origin that still keeps the whole view inside the map.
  function automatic texel_t cam_limit(input int view, input int shift);
    int span;
    span = MAP_DIM - (view >> shift);
    if (span < 0) begin
      return 8'd0;
    end else if (span > 255) begin
      return 8'd255;
    end else begin
      return texel_t'(span);
    end
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth register delay line for the VGA timing bundle; also exposes
// the low TAP_W bits one stage before the end for output-aligned decisions.
module vga_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 26,
  parameter int TAP_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_data,
  output logic [TAP_W-1:0] o_tap
);

  logic [DEPTH-1:0][W-1:0] r_pipe;

  // Shift register: stage 0 takes the input, each later stage the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];
  assign o_tap  = r_pipe[DEPTH-2][TAP_W-1:0];

endmodule

// File: rtl/draw_map_stage.sv
// Scrolling tile-map pixel stage: address -> external ROM -> blanked RGB.
// Optional collision probes are built when MAP_COLLISION_EN is defined.
module draw_map_stage
  import map_pkg::*;
#(
  parameter int          SCALE_SHIFT = 2,
  parameter int          VIEW_W      = 1024,
  parameter int          VIEW_H      = 768,
  parameter logic [11:0] SOLID_RGB   = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [7:0]  cam_x_req,
  input  logic [7:0]  cam_y_req,
  input  logic        cam_valid,
  output logic        cam_ready,
  output logic [15:0] map_addr,
  input  logic [11:0] map_rgb,
`ifdef MAP_COLLISION_EN
  input  logic [7:0]  probe_x0,
  input  logic [7:0]  probe_y0,
  input  logic [7:0]  probe_x1,
  input  logic [7:0]  probe_y1,
  input  logic        probe_valid,
  output logic [15:0] probe_addr0,
  output logic [15:0] probe_addr1,
  input  logic [11:0] probe_rgb0,
  input  logic [11:0] probe_rgb1,
  output logic        probe_done,
  output logic        solid0,
  output logic        solid1,
  output logic        probe_busy,
`endif
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam texel_t CAM_X_LIM = cam_limit(VIEW_W, SCALE_SHIFT);
  localparam texel_t CAM_Y_LIM = cam_limit(VIEW_H, SCALE_SHIFT);

  cam_state_t       r_cam_state, w_cam_state_nxt;
  logic             r_vblnk_prev;
  logic             r_cam_ready;
  texel_t           r_cam_x, r_cam_y;
  texel_t           w_map_x, w_map_y;
  map_addr_t        r_map_addr;
  logic [11:0]      r_rgb;
  logic [VGA_W-1:0] w_vga_in, w_vga_out;
  logic [1:0]       w_blank_tap;

  assign w_map_x = texel_t'(hcount_in >> SCALE_SHIFT) + r_cam_x;
  assign w_map_y = texel_t'(vcount_in >> SCALE_SHIFT) + r_cam_y;

  // Stage A: map address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map_addr <= 16'h0000;
    end else begin
      r_map_addr <= {w_map_y, w_map_x};
    end
  end

  // Camera FSM next state: toggles on vblank edges only.
  always_comb begin
    w_cam_state_nxt = r_cam_state;
    case (r_cam_state)
      CAM_ACTIVE: begin
        if (vblnk_in && !r_vblnk_prev) begin
          w_cam_state_nxt = CAM_BLANK;
        end else begin
          w_cam_state_nxt = CAM_ACTIVE;
        end
      end
      CAM_BLANK: begin
        if (!vblnk_in && r_vblnk_prev) begin
          w_cam_state_nxt = CAM_ACTIVE;
        end else begin
          w_cam_state_nxt = CAM_BLANK;
        end
      end
      default: w_cam_state_nxt = CAM_ACTIVE;
    endcase
  end

  // Camera state, handshake and clamped origin; origin only moves during blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cam_state  <= CAM_ACTIVE;
      r_vblnk_prev <= 1'b0;
      r_cam_ready  <= 1'b0;
      r_cam_x      <= 8'd0;
      r_cam_y      <= 8'd0;
    end else begin
      r_cam_state  <= w_cam_state_nxt;
      r_vblnk_prev <= vblnk_in;
      r_cam_ready  <= (w_cam_state_nxt == CAM_BLANK);
      if (cam_valid && r_cam_ready) begin
        r_cam_x <= (cam_x_req > CAM_X_LIM) ? CAM_X_LIM : cam_x_req;
        r_cam_y <= (cam_y_req > CAM_Y_LIM) ? CAM_Y_LIM : cam_y_req;
      end
    end
  end

  assign w_vga_in = {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in};

  vga_delay #(
    .DEPTH (3),
    .W     (VGA_W),
    .TAP_W (2)
  ) u_vga_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_vga_in),
    .o_data (w_vga_out),
    .o_tap  (w_blank_tap)
  );

  // Stage C: the tap is the blank state that leaves alongside this pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= 12'h000;
    end else begin
      r_rgb <= (|w_blank_tap) ? 12'h000 : map_rgb;
    end
  end

  assign {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out} = w_vga_out;
  assign rgb_out   = r_rgb;
  assign map_addr  = r_map_addr;
  assign cam_ready = r_cam_ready;

`ifdef MAP_COLLISION_EN
  probe_state_t r_prb_state, w_prb_state_nxt;
  map_addr_t    r_probe_addr0, r_probe_addr1;
  logic         r_probe_done, r_solid0, r_solid1, r_probe_busy;

  // Probe FSM next state: fixed three-step walk, new requests only in IDLE.
  always_comb begin
    w_prb_state_nxt = r_prb_state;
    case (r_prb_state)
      PRB_IDLE: begin
        if (probe_valid) begin
          w_prb_state_nxt = PRB_ADDR;
        end else begin
          w_prb_state_nxt = PRB_IDLE;
        end
      end
      PRB_ADDR: w_prb_state_nxt = PRB_READ;
      PRB_READ: w_prb_state_nxt = PRB_IDLE;
      default:  w_prb_state_nxt = PRB_IDLE;
    endcase
  end

  // Probe registers: capture points, then classify ROM data one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prb_state   <= PRB_IDLE;
      r_probe_addr0 <= 16'h0000;
      r_probe_addr1 <= 16'h0000;
      r_probe_done  <= 1'b0;
      r_solid0      <= 1'b0;
      r_solid1      <= 1'b0;
      r_probe_busy  <= 1'b0;
    end else begin
      r_prb_state  <= w_prb_state_nxt;
      r_probe_busy <= (w_prb_state_nxt != PRB_IDLE);
      r_probe_done <= (r_prb_state == PRB_READ);
      if (r_prb_state == PRB_IDLE && probe_valid) begin
        r_probe_addr0 <= {probe_y0, probe_x0};
        r_probe_addr1 <= {probe_y1, probe_x1};
      end
      if (r_prb_state == PRB_READ) begin
        r_solid0 <= (probe_rgb0 == SOLID_RGB);
        r_solid1 <= (probe_rgb1 == SOLID_RGB);
      end
    end
  end

  assign probe_addr0 = r_probe_addr0;
  assign probe_addr1 = r_probe_addr1;
  assign probe_done  = r_probe_done;
  assign solid0      = r_solid0;
  assign solid1      = r_solid1;
  assign probe_busy  = r_probe_busy;
`endif

endmodule

// File: tb/tb_draw_map_stage.sv
// Scoreboard bench for draw_map_stage: a driver pushes expected address,
// handshake and pixel results; a negedge monitor pops and compares them.
module tb_draw_map_stage;

  localparam int SHIFT  = 2;
  localparam int VW     = 768;
  localparam int VH     = 768;
  localparam int X_LIM  = 256 - (VW >> SHIFT);
  localparam int Y_LIM  = 256 - (VH >> SHIFT);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] vcount_in = 11'd0, hcount_in = 11'd0;
  logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
  logic [7:0]  cam_x_req = 8'd0, cam_y_req = 8'd0;
  logic        cam_valid = 1'b0;
  logic        cam_ready;
  logic [15:0] map_addr;
  logic [11:0] map_rgb = 12'h000;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;
`ifdef MAP_COLLISION_EN
  logic [7:0]  probe_x0 = 8'd0, probe_y0 = 8'd0, probe_x1 = 8'd0, probe_y1 = 8'd0;
  logic        probe_valid = 1'b0;
  logic [15:0] probe_addr0, probe_addr1;
  logic [11:0] probe_rgb0 = 12'h000, probe_rgb1 = 12'h000;
  logic        probe_done, solid0, solid1, probe_busy;
`endif

  draw_map_stage #(.SCALE_SHIFT(SHIFT), .VIEW_W(VW), .VIEW_H(VH), .SOLID_RGB(12'h000)) dut (
    .clk(clk), .rst_n(rst_n),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .cam_x_req(cam_x_req), .cam_y_req(cam_y_req), .cam_valid(cam_valid), .cam_ready(cam_ready),
    .map_addr(map_addr), .map_rgb(map_rgb),
`ifdef MAP_COLLISION_EN
    .probe_x0(probe_x0), .probe_y0(probe_y0), .probe_x1(probe_x1), .probe_y1(probe_y1),
    .probe_valid(probe_valid), .probe_addr0(probe_addr0), .probe_addr1(probe_addr1),
    .probe_rgb0(probe_rgb0), .probe_rgb1(probe_rgb1), .probe_done(probe_done),
    .solid0(solid0), .solid1(solid1), .probe_busy(probe_busy),
`endif
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Map ROM contents: two fixed texels for the probe case, a hash elsewhere.
  function automatic logic [11:0] rom_f(input logic [15:0] a);
    if (a == 16'h0503) return 12'h000;
    else if (a == 16'h0907) return 12'h0F0;
    else return a[11:0] ^ {a[15:8], 4'h5};
  endfunction

  // Registered-read ROM models.
  always @(posedge clk) map_rgb <= rom_f(map_addr);
`ifdef MAP_COLLISION_EN
  always @(posedge clk) begin
    probe_rgb0 <= rom_f(probe_addr0);
    probe_rgb1 <= rom_f(probe_addr1);
  end
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [25:0] timing;
    logic [11:0] rgb;
    logic        chk_rgb;
  } pix_t;
  typedef struct {
    int          due;
    logic [15:0] val;
  } val_t;

  pix_t q_pix[$];
  val_t q_addr[$];
  val_t q_rdy[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference state: camera origin and whether the last sampled vblank was high.
  int   mdl_cx = 0, mdl_cy = 0;
  logic mdl_prev_vb = 1'b0;

  task automatic drive(input int h, input int v, input logic hb, input logic vb,
                       input logic cv, input int rx, input int ry);
    logic [15:0] a;
    logic        hs, vs;
    @(posedge clk);
    #1;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb; hsync_in = hs; vsync_in = vs;
    cam_valid = cv; cam_x_req = 8'(rx); cam_y_req = 8'(ry);
    a[7:0]  = 8'(((h >> SHIFT) + mdl_cx) % 256);
    a[15:8] = 8'(((v >> SHIFT) + mdl_cy) % 256);
    q_rdy.push_back('{due: cyc, val: {15'd0, mdl_prev_vb}});
    q_addr.push_back('{due: cyc + 1, val: a});
    q_pix.push_back('{due: cyc + 3, timing: {11'(v), 11'(h), vs, hs, vb, hb},
                      rgb: (hb || vb) ? 12'h000 : rom_f(a), chk_rgb: 1'b1});
    // Camera accepts only while a blank interval is already in progress.
    if (cv && mdl_prev_vb) begin
      mdl_cx = (rx > X_LIM) ? X_LIM : rx;
      mdl_cy = (ry > Y_LIM) ? Y_LIM : ry;
    end
    mdl_prev_vb = vb;
  endtask

  // Monitor: pop every expectation whose cycle has arrived.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q_rdy.size() > 0 && q_rdy[0].due <= cyc) begin
        check("cam_ready", {31'd0, cam_ready}, {16'd0, q_rdy[0].val});
        void'(q_rdy.pop_front());
      end
      while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
        check("map_addr", {16'd0, map_addr}, {16'd0, q_addr[0].val});
        void'(q_addr.pop_front());
      end
      while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
        check("timing_out",
              {6'd0, vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out},
              {6'd0, q_pix[0].timing});
        if (q_pix[0].chk_rgb) check("rgb_out", {20'd0, rgb_out}, {20'd0, q_pix[0].rgb});
        void'(q_pix.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_timing"},
          {6'd0, vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}, 32'd0);
    check({nm, "_rgb"}, {20'd0, rgb_out}, 32'd0);
    check({nm, "_addr"}, {16'd0, map_addr}, 32'd0);
    check({nm, "_ready"}, {31'd0, cam_ready}, 32'd0);
  endtask

  task automatic mid_reset();
    int r;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    q_pix.delete(); q_addr.delete(); q_rdy.delete();
    mdl_cx = 0; mdl_cy = 0; mdl_prev_vb = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    r = cyc;
    for (int k = 0; k < 3; k++) begin
      q_pix.push_back('{due: r + k, timing: 26'd0, rgb: 12'h000, chk_rgb: 1'b0});
    end
  endtask

`ifdef MAP_COLLISION_EN
  task automatic probe_test();
    int n, extra;
    bit seen;
    @(posedge clk); #1;
    probe_x0 = 8'd3; probe_y0 = 8'd5; probe_x1 = 8'd7; probe_y1 = 8'd9; probe_valid = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    check("probe_busy", {31'd0, probe_busy}, 32'd1);
    probe_x0 = 8'd1; probe_y0 = 8'd1; probe_x1 = 8'd2; probe_y1 = 8'd2;
    @(posedge clk); #1;
    probe_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = probe_done;
    end
    check("probe_done_seen", {31'd0, seen}, 32'd1);
    check("probe_latency", 32'(cyc - n), 32'd3);
    check("probe_solid0", {31'd0, solid0}, 32'd1);
    check("probe_solid1", {31'd0, solid1}, 32'd0);
    check("probe_addr0", {16'd0, probe_addr0}, 32'h0503);
    check("probe_addr1", {16'd0, probe_addr1}, 32'h0907);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (probe_done) extra++;
    end
    check("probe_second_ignored", 32'(extra), 32'd0);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    hcount_in = 11'd100; vcount_in = 11'd50; hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1;
    #12;
    check_all_zero("power_on_reset");
    hblnk_in = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed: basic address, horizontal blanking.
    drive(8, 4, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(8, 4, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1020, 760, 1'b0, 1'b0, 1'b0, 0, 0);
    // Blank: clamp of (200,10), then last of several requests wins.
    drive(0, 770, 1'b0, 1'b1, 1'b1, 200, 10);
    drive(0, 771, 1'b0, 1'b1, 1'b1, 200, 10);
    drive(4, 4, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(0, 772, 1'b0, 1'b1, 1'b1, 5, 6);
    drive(0, 773, 1'b0, 1'b1, 1'b1, 200, 10);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Active: requests ignored; h=1020 wraps map_x to 8'h3F.
    drive(1020, 0, 1'b0, 1'b0, 1'b1, 1, 1);
    drive(1020, 0, 1'b0, 1'b0, 1'b1, 1, 1);
    drive(8, 4, 1'b0, 1'b0, 1'b0, 0, 0);

`ifdef MAP_COLLISION_EN
    probe_test();
`endif

    // Random frames: blank interval with random requests, then active pixels.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) begin
        drive($urandom_range(0, 2047), $urandom_range(768, 2047), 1'($urandom_range(0, 1)), 1'b1,
              1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255));
      end
      for (int i = 0; i < 60; i++) begin
        drive($urandom_range(0, 2047), $urandom_range(0, 2047), 1'($urandom_range(0, 3) == 0),
              1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255));
      end
    end

    // Set camera to (10,10), render, then reset mid-frame.
    drive(0, 780, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(0, 781, 1'b0, 1'b1, 1'b1, 10, 10);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) drive(i * 40, 20, 1'b0, 1'b0, 1'b0, 0, 0);
    mid_reset();
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 1023), $urandom_range(0, 767), 1'($urandom_range(0, 3) == 0),
            1'b0, 1'b0, 0, 0);
    end

    repeat (6) @(posedge clk);
    #1;
    check("queues_drained", 32'(q_pix.size() + q_addr.size() + q_rdy.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
